// File: rtl/sng_scheduler.sv
// Round-robin front end sharing one QUOTA+WEYL SNG among N_REQ requesters.
// Optional ones total output (oOnes) is built when SNG_ONES_CHECK_EN is defined.
module sng_scheduler #(
  parameter int N_REQ     = 4,
  parameter int BITSTREAM = 64,
  parameter int BASE      = 61,
  parameter int STRIDE    = 17,
  parameter int QUANT     = 8,
  parameter int CHUNK     = 8,
  localparam int ID_W  = (N_REQ < 2) ? 1 : $clog2(N_REQ),
  localparam int BEATS = BITSTREAM / CHUNK,
  localparam int OW    = $clog2(BITSTREAM) + 1
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic [N_REQ-1:0]       iReqValid,
  input  logic [N_REQ*QUANT-1:0] iReqData,
  output logic [N_REQ-1:0]       oReqReady,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [CHUNK-1:0]       oChunk,
  output logic [ID_W-1:0]        oId,
`ifdef SNG_ONES_CHECK_EN
  output logic                   oLast,
  output logic [OW-1:0]          oOnes
`else
  output logic                   oLast
`endif
);

  localparam int CW = $clog2(BEATS) + 1;
  localparam int QW = OW;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  state_t                 state;
  logic [ID_W-1:0]        ptr;
  logic [QUANT-1:0]       dataReg;
  logic [BITSTREAM-1:0]   shreg;
  logic [BITSTREAM-1:0]   nextSh;
  logic [CW-1:0]          cnt;
  logic                   grantAny;
  logic [ID_W-1:0]        grantIdx;
  logic [QUANT+QW-1:0]    prod;
  logic [QW-1:0]          quota;
  logic [BITSTREAM-1:0]   sngBits;

  // SNG: quota of ones placed at the Weyl-sequence positions below it
  assign prod  = {{QW{1'b0}}, dataReg} * (QUANT+QW)'(BITSTREAM);
  assign quota = QW'(prod >> QUANT);

  for (genvar k = 0; k < BITSTREAM; k++) begin : gWeyl
    localparam int POS = (BASE + k * STRIDE) % BITSTREAM;
    assign sngBits[k] = (quota > QW'(POS));
  end

  assign nextSh = shreg >> CHUNK;

  // Round-robin search starting one past the last granted index
  always_comb begin
    int idx;
    grantAny = 1'b0;
    grantIdx = '0;
    idx      = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grantAny && iReqValid[ID_W'(idx)]) begin
        grantAny = 1'b1;
        grantIdx = ID_W'(idx);
      end
    end
  end

  // Grant is only offered while idle
  always_comb begin
    oReqReady = '0;
    if (state == IDLE && grantAny) oReqReady[grantIdx] = 1'b1;
  end

  // Control FSM with registered beat outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= IDLE;
      ptr     <= ID_W'(N_REQ - 1);
      dataReg <= '0;
      shreg   <= '0;
      cnt     <= '0;
      oValid  <= 1'b0;
      oLast   <= 1'b0;
      oChunk  <= '0;
      oId     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grantAny) begin
            dataReg <= iReqData[grantIdx*QUANT +: QUANT];
            oId     <= grantIdx;
            ptr     <= grantIdx;
            state   <= LOAD;
          end
        end
        LOAD: begin
          shreg  <= sngBits;
          cnt    <= '0;
          oValid <= 1'b1;
          oChunk <= sngBits[CHUNK-1:0];
          oLast  <= (BEATS == 1);
          state  <= SEND;
        end
        SEND: begin
          if (iReady) begin
            if (cnt == CW'(BEATS - 1)) begin
              cnt    <= '0;
              oValid <= 1'b0;
              oLast  <= 1'b0;
              oChunk <= '0;
              state  <= IDLE;
            end else begin
              shreg  <= nextSh;
              oChunk <= nextSh[CHUNK-1:0];
              cnt    <= cnt + 1'b1;
              oLast  <= (cnt + 1'b1 == CW'(BEATS - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SNG_ONES_CHECK_EN
  logic [OW-1:0] onesAcc;

  function automatic logic [OW-1:0] popcnt(input logic [CHUNK-1:0] v);
    popcnt = '0;
    for (int i = 0; i < CHUNK; i++) popcnt = popcnt + OW'(v[i]);
  endfunction

  // Ones accumulator; the total is published after the final beat
  always_ff @(posedge iClk) begin
    if (iRst) begin
      onesAcc <= '0;
      oOnes   <= '0;
    end else if (state == LOAD) begin
      onesAcc <= '0;
      oOnes   <= '0;
    end else if (state == SEND && iReady) begin
      onesAcc <= onesAcc + popcnt(oChunk);
      if (oLast) oOnes <= onesAcc + popcnt(oChunk);
    end
  end
`endif

endmodule

// File: tb/tb_sng_scheduler.sv
// Directed bench for sng_scheduler at default parameters.
// Vector table for grant order plus hand-written stall/reset/skip sequences.
module tb_sng_scheduler;

  logic        clk = 1'b0;
  logic        iRst;
  logic [3:0]  iReqValid;
  logic [31:0] iReqData;
  logic [3:0]  oReqReady;
  logic        oValid;
  logic        iReady;
  logic [7:0]  oChunk;
  logic [1:0]  oId;
  logic        oLast;
`ifdef SNG_ONES_CHECK_EN
  logic [6:0]  oOnes;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sng_scheduler dut (
    .iClk      (clk),
    .iRst      (iRst),
    .iReqValid (iReqValid),
    .iReqData  (iReqData),
    .oReqReady (oReqReady),
    .oValid    (oValid),
    .iReady    (iReady),
    .oChunk    (oChunk),
    .oId       (oId),
`ifdef SNG_ONES_CHECK_EN
    .oLast     (oLast),
    .oOnes     (oOnes)
`else
    .oLast     (oLast)
`endif
  );

  typedef struct {
    bit          doReset;
    logic [3:0]  valid;
    logic [31:0] data;
    int          expId;
    int          expOnes;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] sngModel(input logic [7:0] d);
    int q;
    logic [63:0] s;
    q = (int'(d) * 64) / 256;
    for (int k = 0; k < 64; k++) s[k] = (((61 + 17 * k) % 64) < q);
    return s;
  endfunction

  task automatic doReset();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
  endtask

  task automatic grab(input logic [3:0] v, input logic [31:0] d,
                      input int expId);
    int w;
    iReqValid = v;
    iReqData  = d;
    #1;
    w = 0;
    while (oReqReady == 4'b0 && w < 40) begin
      tick();
      w++;
    end
    chk("grant", {60'b0, oReqReady}, 64'(1) << expId);
    tick();
  endtask

  task automatic collect(input int id, input logic [7:0] d,
                         input int stallBeat, input int pulseBeat,
                         input int expOnes);
    logic [63:0] m;
    logic [7:0]  sc;
    logic [1:0]  si;
    logic        sl;
    int w;
    int ones;
    m = sngModel(d);
    w = 0;
    while (!oValid && w < 6) begin
      tick();
      w++;
    end
    chk("loadLatency", w, 1);
    if (!oValid) return;
    ones = 0;
    for (int b = 0; b < 8; b++) begin
      chk("beatValid", oValid, 1);
      chk("chunk", oChunk, m[b*8 +: 8]);
      chk("id", oId, id);
      chk("last", oLast, (b == 7));
      chk("readyInSend", oReqReady, 0);
      ones += $countones(oChunk);
      if (b == stallBeat) begin
        sc = oChunk;
        si = oId;
        sl = oLast;
        iReady = 1'b0;
        repeat (5) begin
          tick();
          chk("stallValid", oValid, 1);
          chk("stallChunk", oChunk, sc);
          chk("stallId", oId, si);
          chk("stallLast", oLast, sl);
        end
        iReady = 1'b1;
      end
      if (pulseBeat >= 0 && b == pulseBeat) iReqValid = 4'b1000;
      else if (pulseBeat >= 0 && b == pulseBeat + 1) iReqValid = 4'b0;
      tick();
    end
    chk("onesCount", ones, expOnes);
    chk("doneValid", oValid, 0);
`ifdef SNG_ONES_CHECK_EN
    chk("oOnes", oOnes, expOnes);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[$];
    int firstV;

    iRst      = 1'b1;
    iReqValid = 4'b0;
    iReqData  = 32'b0;
    iReady    = 1'b1;

    vecs[0] = '{1'b1, 4'b0010, 32'h0000_0000, 1, 0};
    vecs[1] = '{1'b1, 4'b1111, 32'h281E_140A, 0, 2};
    vecs[2] = '{1'b0, 4'b1111, 32'h281E_140A, 1, 5};
    vecs[3] = '{1'b0, 4'b1111, 32'h281E_140A, 2, 7};
    vecs[4] = '{1'b0, 4'b1111, 32'h281E_140A, 3, 10};
    vecs[5] = '{1'b0, 4'b1111, 32'h281E_140A, 0, 2};

    tick();
    tick();
    chk("rstValid", oValid, 0);
    chk("rstLast", oLast, 0);
    chk("rstChunk", oChunk, 0);
    chk("rstId", oId, 0);
    chk("rstReady", oReqReady, 0);
    iRst = 1'b0;

    // tests 1 and 2: single requester, then round-robin order
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].doReset) begin
        iReqValid = 4'b0;
        doReset();
      end
      grab(vecs[i].valid, vecs[i].data, vecs[i].expId);
      collect(vecs[i].expId, vecs[i].data[vecs[i].expId*8 +: 8],
              -1, -1, vecs[i].expOnes);
    end

    // test 3: one requester held valid, accept spacing
    iReqValid = 4'b0;
    doReset();
    iReqValid = 4'b0100;
    iReqData  = 32'h004D_0000;
    firstV    = -1;
    for (int c = 0; c < 26; c++) begin
      #1;
      if (oReqReady[2]) grants.push_back(cyc);
      if (oValid && firstV < 0) firstV = cyc;
      tick();
    end
    chk("numAccepts", grants.size(), 3);
    if (grants.size() >= 3) begin
      chk("period1", grants[1] - grants[0], 10);
      chk("period2", grants[2] - grants[1], 10);
      chk("firstBeat", firstV - grants[0], 2);
    end

    // test 4: downstream stall during beat 3
    iReqValid = 4'b0;
    doReset();
    grab(4'b0001, 32'h0000_0028, 0);
    iReqValid = 4'b0;
    collect(0, 8'd40, 2, -1, 10);

    // test 5: reset in the middle of beat 4
    doReset();
    grab(4'b0010, 32'h0000_1E00, 1);
    iReqValid = 4'b0;
    begin
      int w;
      w = 0;
      while (!oValid && w < 6) begin
        tick();
        w++;
      end
    end
    repeat (3) tick();
    chk("preRstValid", oValid, 1);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    chk("midRstValid", oValid, 0);
    chk("midRstLast", oLast, 0);
    chk("midRstChunk", oChunk, 0);
    chk("midRstId", oId, 0);
    iReqValid = 4'b1001;
    iReqData  = 32'h3200_0028;
    #1;
    chk("postRstGrant", oReqReady, 4'b0001);
    tick();
    iReqValid = 4'b0;
    collect(0, 8'd40, -1, -1, 10);

    // test 6: short-lived request during SEND is skipped
    doReset();
    grab(4'b0001, 32'h5A00_000A, 0);
    iReqValid = 4'b0;
    collect(0, 8'd10, -1, 1, 2);
    repeat (6) begin
      chk("skipValid", oValid, 0);
      chk("skipReady", oReqReady, 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
